// File: rtl/line_ring_scaler.sv
// rtl/line_ring_scaler.sv - line ring buffer with fractional DDA horizontal scaler and pillarbox borders
module line_ring_scaler #(
    parameter int CH_W      = 8,
    parameter int CHANNELS  = 3,
    parameter int LINE_BUFS = 8,
    parameter int LINE_W    = 11,
    parameter int FRAC_W    = 12,
    parameter int OUT_W     = 12,
    parameter int PIX_W     = CH_W * CHANNELS,
    parameter int FILL_W    = $clog2(LINE_BUFS) + 1
) (
    input  logic                clk_out,
    input  logic                reset,
    input  logic                i_frame_start,
    input  logic                i_line_start,
    input  logic                i_valid,
    input  logic [PIX_W-1:0]    i_pix,
    input  logic                i_out_line_start,
    input  logic                i_out_req,
    input  logic [FRAC_W+1:0]   i_step,
    input  logic [LINE_W-1:0]   i_hoffset,
    input  logic [OUT_W-1:0]    i_out_width,
    input  logic [OUT_W-1:0]    i_border,
    output logic [PIX_W-1:0]    o_pix,
    output logic                o_valid,
    output logic                o_overrun,
    output logic                o_underrun,
    output logic [FILL_W-1:0]   o_fill
);

    localparam int LB_W     = $clog2(LINE_BUFS);
    localparam int ACC_W    = LINE_W + FRAC_W + 1;
    localparam int WA_W     = LINE_W + 1;
    localparam int MAX_FILL = LINE_BUFS - 2;
    localparam int DEPTH    = LINE_BUFS * (2 ** LINE_W);
    localparam logic [LINE_BUFS-1:0] ONE = LINE_BUFS'(1);

    // Pixel storage: one LINE_W-addressed line per ring slot.
    logic [PIX_W-1:0]     ram [0:DEPTH-1];

    // Ring bookkeeping. Committed lines are kept as an ordered queue of slot
    // numbers so that an overrun can recycle the oldest slot without ever
    // touching the slot that is being read.
    logic [LB_W-1:0]      wr_line;
    logic [LB_W-1:0]      rd_line;
    logic [LB_W-1:0]      q_head;
    logic [LB_W-1:0]      order_q [0:LINE_BUFS-1];
    logic [LINE_BUFS-1:0] cmask;
    logic [FILL_W-1:0]    fill;
    logic [WA_W-1:0]      wr_addr;
    logic [WA_W-1:0]      len [0:LINE_BUFS-1];

    // Read side.
    logic [ACC_W-1:0]     acc;
    logic [OUT_W-1:0]     out_x;
    logic                 s1_valid;
    logic                 s1_black;
    logic [LB_W+LINE_W-1:0] s1_addr;

    // Next-state terms for the ring.
    logic                 commit;
    logic                 consume;
    logic                 overrun_c;
    logic                 underrun_c;
    logic [FILL_W-1:0]    fill_a;
    logic [FILL_W-1:0]    fill_b;
    logic [FILL_W-1:0]    fill_n;
    logic [LINE_BUFS-1:0] cmask_a;
    logic [LINE_BUFS-1:0] cmask_b;
    logic [LINE_BUFS-1:0] cmask_n;
    logic [LINE_BUFS-1:0] busy;
    logic [LB_W-1:0]      wr_a;
    logic [LB_W-1:0]      wr_n;
    logic [LB_W-1:0]      rd_n;
    logic [LB_W-1:0]      head_b;
    logic [LB_W-1:0]      head_n;
    logic [LB_W-1:0]      tail;
    logic [LB_W-1:0]      drop_line;
    logic [LB_W-1:0]      free_line;
    logic                 free_found;

    // Read-side combinational terms.
    logic [LINE_W-1:0]    src;
    logic                 rd_active;
    logic                 rd_border;
    logic                 rd_black;

    assign o_fill = fill;

    // Ring update order: frame restart, then consume (sees pre-commit queue), then commit.
    always_comb begin
        commit     = i_line_start && (wr_addr != '0) && !i_frame_start;
        fill_a     = i_frame_start ? '0 : fill;
        cmask_a    = i_frame_start ? '0 : cmask;
        wr_a       = i_frame_start ? rd_line + 1'b1 : wr_line;

        consume    = i_out_line_start && (fill_a != '0);
        underrun_c = i_out_line_start && (fill_a == '0);
        rd_n       = consume ? order_q[q_head] : rd_line;
        head_b     = consume ? q_head + 1'b1 : q_head;
        fill_b     = consume ? fill_a - 1'b1 : fill_a;
        cmask_b    = consume ? (cmask_a & ~(ONE << rd_n)) : cmask_a;

        busy       = cmask_b | (ONE << rd_n) | (ONE << wr_a);
        free_line  = '0;
        free_found = 1'b0;
        for (int i = 0; i < LINE_BUFS; i++) begin
            if (!busy[i] && !free_found) begin
                free_line  = LB_W'(i);
                free_found = 1'b1;
            end
        end

        drop_line  = order_q[head_b];
        tail       = head_b + fill_b[LB_W-1:0];
        overrun_c  = commit && (fill_b == FILL_W'(MAX_FILL));

        wr_n    = wr_a;
        head_n  = head_b;
        fill_n  = fill_b;
        cmask_n = cmask_b;
        if (commit) begin
            cmask_n = cmask_b | (ONE << wr_a);
            if (overrun_c) begin
                wr_n    = drop_line;
                head_n  = head_b + 1'b1;
                cmask_n = cmask_n & ~(ONE << drop_line);
            end else begin
                wr_n    = free_line;
                fill_n  = fill_b + 1'b1;
            end
        end
    end

    // Ring state, line lengths, write address and status pulses.
    always_ff @(posedge clk_out) begin
        if (reset) begin
            wr_line    <= LB_W'(1);
            rd_line    <= '0;
            q_head     <= '0;
            fill       <= '0;
            cmask      <= '0;
            wr_addr    <= '0;
            o_overrun  <= 1'b0;
            o_underrun <= 1'b0;
            for (int i = 0; i < LINE_BUFS; i++) begin
                len[i] <= '0;
            end
        end else begin
            wr_line    <= wr_n;
            rd_line    <= rd_n;
            q_head     <= head_n;
            fill       <= fill_n;
            cmask      <= cmask_n;
            o_overrun  <= overrun_c;
            o_underrun <= underrun_c;
            if (commit) begin
                len[wr_line] <= wr_addr;
            end
            if (i_frame_start || commit) begin
                wr_addr <= '0;
            end else if (i_valid && !wr_addr[LINE_W]) begin
                wr_addr <= wr_addr + 1'b1;
            end
        end
    end

    // Commit order queue; entries beyond fill are don't-care so no reset.
    always_ff @(posedge clk_out) begin
        if (!reset && commit) begin
            order_q[tail] <= wr_line;
        end
    end

    // Source pixel write; pixels past the last address of a line are dropped.
    always_ff @(posedge clk_out) begin
        if (i_valid && !wr_addr[LINE_W]) begin
            ram[{wr_line, wr_addr[LINE_W-1:0]}] <= i_pix;
        end
    end

    // Per-request classification: idle, border, overflowed or past end of line -> black.
    always_comb begin
        src       = acc[LINE_W+FRAC_W-1:FRAC_W];
        rd_active = out_x < i_out_width;
        rd_border = (out_x < i_border) ||
                    (({1'b0, out_x} + {1'b0, i_border}) >= {1'b0, i_out_width});
        rd_black  = !rd_active || rd_border || acc[ACC_W-1] ||
                    ({1'b0, src} >= len[rd_line]);
    end

    // DDA stepping and the two-stage read pipeline.
    always_ff @(posedge clk_out) begin
        if (reset) begin
            acc      <= '0;
            out_x    <= i_out_width;
            s1_valid <= 1'b0;
            s1_black <= 1'b1;
            s1_addr  <= '0;
            o_valid  <= 1'b0;
            o_pix    <= '0;
        end else begin
            s1_valid <= i_out_req;
            s1_black <= rd_black;
            s1_addr  <= {rd_line, src};
            o_valid  <= s1_valid;
            o_pix    <= (s1_valid && !s1_black) ? ram[s1_addr] : '0;
            if (i_out_line_start) begin
                acc   <= {1'b0, i_hoffset, {FRAC_W{1'b0}}};
                out_x <= '0;
            end else if (i_out_req && rd_active) begin
                out_x <= out_x + 1'b1;
                if (!rd_border && !acc[ACC_W-1]) begin
                    acc <= acc + ACC_W'(i_step);
                end
            end
        end
    end

endmodule

// File: tb/tb_line_ring_scaler.sv
// tb/tb_line_ring_scaler.sv - self-checking bench for line_ring_scaler
module tb_line_ring_scaler;

    localparam int MAXF = 6;

    logic        clk_out = 1'b0;
    logic        reset;
    logic        i_frame_start;
    logic        i_line_start;
    logic        i_valid;
    logic [23:0] i_pix;
    logic        i_out_line_start;
    logic        i_out_req;
    logic [13:0] i_step;
    logic [10:0] i_hoffset;
    logic [11:0] i_out_width;
    logic [11:0] i_border;
    logic [23:0] o_pix;
    logic        o_valid;
    logic        o_overrun;
    logic        o_underrun;
    logic [3:0]  o_fill;

    line_ring_scaler dut (
        .clk_out          (clk_out),
        .reset            (reset),
        .i_frame_start    (i_frame_start),
        .i_line_start     (i_line_start),
        .i_valid          (i_valid),
        .i_pix            (i_pix),
        .i_out_line_start (i_out_line_start),
        .i_out_req        (i_out_req),
        .i_step           (i_step),
        .i_hoffset        (i_hoffset),
        .i_out_width      (i_out_width),
        .i_border         (i_border),
        .o_pix            (o_pix),
        .o_valid          (o_valid),
        .o_overrun        (o_overrun),
        .o_underrun       (o_underrun),
        .o_fill           (o_fill)
    );

    always #5 clk_out = ~clk_out;

    int vecs = 0;
    int errs = 0;

    // Reference model: source lines stored by id, committed lines as a FIFO of ids.
    logic [23:0] lp [0:63][0:2047];
    int          llen [0:63];
    int          cq [$];
    int          wid = 0;
    int          wr_cnt = 0;
    int          rd_id = -1;
    int          cw, cb, cst, cho;

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int x);
        longint pos;
        longint srcl;
        if (x >= cw) return 24'h0;
        if (x < cb || x >= cw - cb) return 24'h0;
        pos  = longint'(cho) * 4096 + longint'(x - cb) * longint'(cst);
        srcl = pos / 4096;
        if (rd_id < 0) return 24'h0;
        if (srcl >= longint'(llen[rd_id])) return 24'h0;
        return lp[rd_id][int'(srcl)];
    endfunction

    task automatic src_pixels(input int n, input bit ramp);
        for (int k = 0; k < n; k++) begin
            logic [23:0] p;
            p = ramp ? 24'(k) : 24'($urandom);
            i_valid = 1'b1;
            i_pix   = p;
            if (wr_cnt < 2048) begin
                lp[wid][wr_cnt] = p;
                wr_cnt++;
            end
            tick();
        end
        i_valid = 1'b0;
    endtask

    task automatic src_line_start();
        logic exp_over;
        exp_over = 1'b0;
        if (wr_cnt > 0) begin
            if (cq.size() == MAXF) begin
                cq.delete(0);
                exp_over = 1'b1;
            end
            llen[wid] = wr_cnt;
            cq.push_back(wid);
            wid++;
            wr_cnt = 0;
        end
        i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        chk("overrun", {31'b0, o_overrun}, {31'b0, exp_over});
        chk("fill_after_commit", {28'b0, o_fill}, cq.size());
    endtask

    task automatic frame_start();
        cq.delete();
        wr_cnt = 0;
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        chk("fill_after_frame", {28'b0, o_fill}, 0);
        chk("overrun_frame", {31'b0, o_overrun}, 0);
    endtask

    task automatic out_line(input int w, input int b, input int st, input int ho, input int nreq);
        logic        exp_under;
        logic [23:0] expq [$];
        cw = w; cb = b; cst = st; cho = ho;
        i_out_width = 12'(w);
        i_border    = 12'(b);
        i_step      = 14'(st);
        i_hoffset   = 11'(ho);
        exp_under   = (cq.size() == 0);
        if (!exp_under) rd_id = cq.pop_front();
        i_out_line_start = 1'b1;
        tick();
        i_out_line_start = 1'b0;
        chk("underrun", {31'b0, o_underrun}, {31'b0, exp_under});
        chk("fill_after_read", {28'b0, o_fill}, cq.size());
        for (int c = 0; c <= nreq + 1; c++) begin
            i_out_req = (c < nreq);
            if (c < nreq) expq.push_back(exp_pix(c));
            tick();
            if (c == 0) chk("underrun_pulse_end", {31'b0, o_underrun}, 0);
            chk("valid", {31'b0, o_valid}, (c >= 1 && c <= nreq) ? 1 : 0);
            if (c >= 1 && c <= nreq) chk("pix", {8'b0, o_pix}, {8'b0, expq.pop_front()});
        end
    endtask

    initial begin
        reset            = 1'b1;
        i_frame_start    = 1'b0;
        i_line_start     = 1'b0;
        i_valid          = 1'b0;
        i_pix            = '0;
        i_out_line_start = 1'b0;
        i_out_req        = 1'b0;
        i_step           = 14'h1000;
        i_hoffset        = '0;
        i_out_width      = 12'd720;
        i_border         = '0;
        tick();
        tick();
        chk("reset_pix", {8'b0, o_pix}, 0);
        chk("reset_valid", {31'b0, o_valid}, 0);
        chk("reset_overrun", {31'b0, o_overrun}, 0);
        chk("reset_underrun", {31'b0, o_underrun}, 0);
        chk("reset_fill", {28'b0, o_fill}, 0);
        reset = 1'b0;
        tick();

        // Empty ring: underrun, black pixels.
        out_line(10, 0, 'h1000, 0, 10);

        // 720-pixel ramp, 1:1 copy.
        src_pixels(720, 1'b1);
        src_line_start();
        out_line(720, 0, 'h1000, 0, 720);

        // Repeated line: 2x upscale and 1.5 step.
        out_line(1440, 0, 'h0800, 0, 1440);
        out_line(480, 0, 'h1800, 0, 480);

        // Pillarbox, then offset that runs past the end of the source line.
        out_line(1280, 160, 'h0900, 0, 1280);
        out_line(1280, 160, 'h0900, 300, 1280);

        // Seven commits without reads: saturation and overrun.
        for (int j = 0; j < 7; j++) begin
            src_pixels($urandom_range(40, 60), 1'b0);
            src_line_start();
        end
        out_line(64, 0, 'h1000, 0, 64);

        // Frame restart with committed lines and a partial line in progress.
        src_pixels(30, 1'b0);
        frame_start();
        out_line(64, 0, 'h1000, 0, 64);
        src_pixels(50, 1'b0);
        src_line_start();
        out_line(64, 0, 'h1000, 0, 64);

        // Randomised lines and scaler settings.
        for (int it = 0; it < 8; it++) begin
            int nl;
            int w;
            int b;
            int st;
            int ho;
            nl = $urandom_range(0, 3);
            for (int j = 0; j < nl; j++) begin
                src_pixels($urandom_range(1, 150), 1'b0);
                src_line_start();
            end
            if (it == 5) frame_start();
            w  = $urandom_range(20, 200);
            b  = $urandom_range(0, w / 4);
            st = (it == 2) ? 0 : $urandom_range(0, 16383);
            ho = (it == 6) ? 2040 : $urandom_range(0, 160);
            out_line(w, b, st, ho, w + 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
